button_event_arbiter: RTL



---
 rtl/button_event_pkg.sv | 42 ++++
 rtl/button_event_arbiter_btn_channel.sv | 143 ++++++++++++++
 rtl/button_event_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/button_event_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package  : button_event_pkg                                            |
// | Purpose  : Shared types and defaults for the button event arbiter:     |
// |            per-channel state encoding, event record, 100 MHz timing    |
// |            defaults and the counter-width helper.                      |
// | Ports    : none (package)                                              |
// | Config   : BTN_AUTO_REPEAT_EN selects IDLE/HOLD/REPEAT channels;       |
// |            when undefined, CH_HOLD acts as the PRESSED state.          |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
package button_event_pkg;

  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_HOLD   = 2'd1,
    CH_REPEAT = 2'd2
  } ch_state_e;

  // Without auto-repeat the second state simply means "button is down".
  localparam ch_state_e CH_PRESSED = CH_HOLD;

  // Event record as seen by downstream consumers (id zero-extended).
  localparam int EVT_ID_MAX_W = 8;
  typedef struct packed {
    logic [EVT_ID_MAX_W-1:0] id;
    logic                    rpt;
  } evt_t;

  // 0.5 s to first repeat, 0.1 s between repeats at 100 MHz.
  localparam int DEF_HOLD_CYCLES   = 50_000_000;
  localparam int DEF_REPEAT_CYCLES = 10_000_000;

  // Counter must hold max(HOLD,REPEAT)-1; never narrower than one bit.
  function automatic int cnt_width(input int hold_c, input int rep_c);
    int m;
    m = (hold_c > rep_c) ? hold_c : rep_c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_event_arbiter_btn_channel.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : btn_channel                                                 |
// | Purpose  : One button channel: rising-edge detect, press/hold/repeat   |
// |            FSM with down-counter, and a single-entry pending slot.     |
// | Ports    : clk, rst_n (sync, active-low)                               |
// |            btn_lvl_i  debounced level, 1 = pressed                     |
// |            grant_i    arbiter takes this channel's slot this cycle     |
// |            pending_o  slot holds an undelivered event                  |
// |            repeat_o   pending event is an auto-repeat                  |
// |            drop_o     (comb) an event is being discarded this cycle    |
// | Config   : BTN_AUTO_REPEAT_EN enables HOLD/REPEAT counters; otherwise  |
// |            IDLE/PRESSED only and HOLD/REPEAT parameters are unused.    |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module btn_channel
  import button_event_pkg::*;
#(
  parameter int HOLD_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_lvl_i,
  input  logic grant_i,
  output logic pending_o,
  output logic repeat_o,
  output logic drop_o
);

  ch_state_e state_q, state_d;
  logic      btn_q;
  logic      pend_q, pend_d;
  logic      rpt_q, rpt_d;
  logic      w_rise;
  logic      w_raise;
  logic      w_raise_rpt;

  assign w_rise = btn_lvl_i & ~btn_q;

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LOAD  = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Release has priority over an expiring counter, so a repeat is never
  // raised on the edge the button is seen low.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    w_raise     = 1'b0;
    w_raise_rpt = 1'b0;
    case (state_q)
      CH_IDLE: begin
        if (w_rise) begin
          state_d = CH_HOLD;
          w_raise = 1'b1;
          cnt_d   = HOLD_LOAD;
        end
      end
      CH_HOLD, CH_REPEAT: begin
        if (!btn_lvl_i) begin
          state_d = CH_IDLE;
        end else if (cnt_q == '0) begin
          state_d     = CH_REPEAT;
          w_raise     = 1'b1;
          w_raise_rpt = 1'b1;
          cnt_d       = REP_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    state_d     = state_q;
    w_raise     = 1'b0;
    w_raise_rpt = 1'b0;
    case (state_q)
      CH_IDLE: begin
        if (w_rise) begin
          state_d = CH_PRESSED;
          w_raise = 1'b1;
        end
      end
      CH_PRESSED: begin
        if (!btn_lvl_i) state_d = CH_IDLE;
      end
      default: state_d = CH_IDLE;
    endcase
  end
`endif

  // Slot: a grant frees it this cycle, so a coincident new event refills
  // it without loss. Otherwise the event already waiting wins.
  always_comb begin
    pend_d = pend_q;
    rpt_d  = rpt_q;
    drop_o = 1'b0;
    if (grant_i) begin
      pend_d = w_raise;
      rpt_d  = w_raise & w_raise_rpt;
    end else if (w_raise) begin
      if (pend_q) begin
        drop_o = 1'b1;
      end else begin
        pend_d = 1'b1;
        rpt_d  = w_raise_rpt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CH_IDLE;
      btn_q   <= 1'b0;
      pend_q  <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= btn_lvl_i;
      pend_q  <= pend_d;
      rpt_q   <= rpt_d;
    end
  end

  assign pending_o = pend_q;
  assign repeat_o  = rpt_q;

endmodule
`default_nettype wire

// File: rtl/button_event_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : button_event_arbiter                                        |
// | Purpose  : Turns NUM_BTN debounced button levels into press (and       |
// |            optional auto-repeat) events and serializes them through a  |
// |            round-robin arbiter onto one valid/ready event stream.      |
// | Ports    : clk, rst_n (sync, active-low)                               |
// |            btn_lvl[NUM_BTN]  debounced levels, 1 = pressed             |
// |            evt_valid/evt_ready  event handshake                        |
// |            evt_id[ID_W]      originating button index                  |
// |            evt_repeat        0 = press, 1 = auto-repeat                |
// |            evt_drop          1-cycle pulse: event lost to a full slot  |
// | Config   : BTN_AUTO_REPEAT_EN enables hold-to-repeat; when undefined   |
// |            exactly one event per press and evt_repeat stays 0.         |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module button_event_arbiter
  import button_event_pkg::*;
#(
  parameter int NUM_BTN       = 4,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int ID_W          = $clog2(NUM_BTN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_lvl,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [ID_W-1:0]    evt_id,
  output logic               evt_repeat,
  output logic               evt_drop
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, REPEAT_CYCLES);

  logic [NUM_BTN-1:0] w_pend;
  logic [NUM_BTN-1:0] w_rpt;
  logic [NUM_BTN-1:0] w_drop;
  logic [NUM_BTN-1:0] w_grant;

  logic               evt_valid_q;
  logic [ID_W-1:0]    evt_id_q;
  logic               evt_rpt_q;
  logic               evt_drop_q;
  logic [ID_W-1:0]    rr_q, rr_d;

  logic               w_load;
  logic               w_found;
  logic [ID_W-1:0]    w_sel;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_channel #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .CNT_W         (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_lvl_i (btn_lvl[g]),
      .grant_i   (w_grant[g]),
      .pending_o (w_pend[g]),
      .repeat_o  (w_rpt[g]),
      .drop_o    (w_drop[g])
    );
  end

  assign w_load = ~evt_valid_q | evt_ready;

  // Round-robin pick: lowest pending index at or above rr_q, else wrap to
  // the lowest pending index overall. Scanning downward lets the last hit
  // be the lowest index without a variable-index search.
  always_comb begin
    logic            found_hi;
    logic [ID_W-1:0] sel_hi;
    logic [ID_W-1:0] sel_lo;
    found_hi = 1'b0;
    sel_hi   = '0;
    sel_lo   = '0;
    w_found  = 1'b0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (w_pend[i]) begin
        w_found = 1'b1;
        sel_lo  = ID_W'(i);
        if (ID_W'(i) >= rr_q) begin
          found_hi = 1'b1;
          sel_hi   = ID_W'(i);
        end
      end
    end
    w_sel = found_hi ? sel_hi : sel_lo;
  end

  always_comb begin
    w_grant = '0;
    if (w_load && w_found) w_grant[w_sel] = 1'b1;
    if (w_sel == ID_W'(NUM_BTN - 1)) rr_d = '0;
    else                             rr_d = w_sel + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_rpt_q   <= 1'b0;
      evt_drop_q  <= 1'b0;
      rr_q        <= '0;
    end else begin
      evt_drop_q <= |w_drop;
      if (w_load) begin
        evt_valid_q <= w_found;
        if (w_found) begin
          evt_id_q  <= w_sel;
          evt_rpt_q <= w_rpt[w_sel];
          rr_q      <= rr_d;
        end
      end
    end
  end

  assign evt_valid  = evt_valid_q;
  assign evt_id     = evt_id_q;
  assign evt_repeat = evt_rpt_q;
  assign evt_drop   = evt_drop_q;

endmodule
`default_nettype wire
